// File: rtl/debug_frame_tx.sv
// debug_frame_tx: snapshots seven CPU debug bytes on capture and sends them
// as one UART 8N1 frame: SYNC_BYTE, debug_port1..debug_port7.
// Optional macro DEBUG_FRAME_CHECKSUM_EN appends a ninth byte, the XOR of
// the seven latched debug bytes (SYNC_BYTE excluded).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   capture             one-cycle request to latch ports and send a frame
//   debug_port1..7      debug bytes (debug_port1 = pc_curr[7:0])
//   tx                  registered serial line, idle high
//   busy                high while a frame is in flight
//   overrun             sticky, set when capture arrives while busy
module debug_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       capture,
    input  logic [7:0] debug_port1,
    input  logic [7:0] debug_port2,
    input  logic [7:0] debug_port3,
    input  logic [7:0] debug_port4,
    input  logic [7:0] debug_port5,
    input  logic [7:0] debug_port6,
    input  logic [7:0] debug_port7,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

`ifdef DEBUG_FRAME_CHECKSUM_EN
    localparam int NB = 9;
    logic [7:0] chk;
    logic [8*(NB-1)-1:0] snap;
    assign chk = debug_port1 ^ debug_port2 ^ debug_port3 ^ debug_port4
               ^ debug_port5 ^ debug_port6 ^ debug_port7;
    assign snap = {chk, debug_port7, debug_port6, debug_port5,
                   debug_port4, debug_port3, debug_port2, debug_port1};
`else
    localparam int NB = 8;
    logic [8*(NB-1)-1:0] snap;
    assign snap = {debug_port7, debug_port6, debug_port5,
                   debug_port4, debug_port3, debug_port2, debug_port1};
`endif

    localparam logic [3:0] LAST_BYTE = 4'(NB - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_n;
    logic [3:0]  byte_idx, byte_n;
    logic [8*(NB-1)-1:0] payload;
    logic [8*NB-1:0] frame_bits;
    logic [6:0]  sel;
    logic [7:0]  cur_byte;
    logic        tx_n;
    logic        wrap;

    // Byte k of the frame lives at frame_bits[8k +: 8]; byte 0 is the sync.
    assign frame_bits = {payload, SYNC_BYTE};
    assign sel        = {byte_n, 3'b000};
    assign cur_byte   = frame_bits[sel +: 8];
    assign wrap       = (cnt == LAST_CNT);
    assign busy       = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        unique case (state)
            IDLE: begin
                if (capture) begin
                    state_n = START;
                    cnt_n   = '0;
                    bit_n   = '0;
                    byte_n  = '0;
                end
            end
            START: begin
                cnt_n = wrap ? '0 : cnt + 16'd1;
                if (wrap) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                cnt_n = wrap ? '0 : cnt + 16'd1;
                if (wrap) begin
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                cnt_n = wrap ? '0 : cnt + 16'd1;
                if (wrap) begin
                    if (byte_idx == LAST_BYTE) begin
                        state_n = IDLE;
                    end else begin
                        state_n = START;
                        byte_n  = byte_idx + 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // tx is computed from the next state so the register output lines up
    // with the state it belongs to, without a combinational output path.
    always_comb begin
        tx_n = 1'b1;
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = cur_byte[bit_n];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            payload  <= '0;
            tx       <= 1'b1;
            overrun  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            tx       <= tx_n;
            if (capture && state == IDLE) payload <= snap;
            if (capture && state != IDLE) overrun <= 1'b1;
        end
    end

endmodule
